// File: rtl/loop_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loop_det_pkg : shared types and constants for stream_loop_detector |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package loop_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    STREAM  = 2'd3
  } state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int         DEPTH_DEF  = 16;
  localparam int         IDX_W_DEF  = 4;

endpackage
`default_nettype wire

// File: rtl/loop_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loop_buffer : DEPTH x 32 register file, one write / one read port  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module loop_buffer
  import loop_det_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/stream_loop_detector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_loop_detector : captures a short backward loop and replays  |
// | it to decode while stalling fetch. rev 1.0                         |
// +--------------------------------------------------------------------+
module stream_loop_detector
  import loop_det_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] curr_PC,
  input  logic [31:0] instruction,
  input  logic [31:0] immediate,
  input  logic        mispredict,
  output logic [31:0] out_instruction,
  output logic        block_signal,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        reuse_signal
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   len_q, len_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [31:0]      br_q, br_d;
  logic             flush_q, flush_d;
  logic [31:0]      new_pc_q, new_pc_d;

  logic             buf_we;
  logic [IDX_W-1:0] buf_waddr;
  logic [31:0]      buf_rdata;

  logic        w_is_branch;
  logic [31:0] w_neg_imm;
  logic [31:0] w_body_len;
  logic        w_qualify;
  logic [31:0] w_target;
  logic [31:0] w_expect_pc;
  logic        w_capture_abort;
  logic        w_last_rd;

  assign w_is_branch = (instruction[6:0] == OPC_BRANCH);
  assign w_neg_imm   = -immediate;
  assign w_body_len  = w_neg_imm + 32'd1;
  assign w_qualify   = w_is_branch && immediate[31] && (w_body_len <= 32'(DEPTH));
  assign w_target    = curr_PC + {immediate[29:0], 2'b00};

  // Capture must walk the body strictly sequentially from the target.
  assign w_expect_pc = tgt_q + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
  assign w_capture_abort = (curr_PC < tgt_q) || (curr_PC > br_q) ||
                           (curr_PC != w_expect_pc) || ({1'b0, idx_q} >= len_q);
  assign w_last_rd = ({1'b0, idx_q} == (len_q - (IDX_W+1)'(1)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    br_d      = br_q;
    flush_d   = 1'b0;
    new_pc_d  = 32'd0;
    buf_we    = 1'b0;
    buf_waddr = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (!mispredict && w_qualify) begin
          br_d    = curr_PC;
          tgt_d   = w_target;
          len_d   = w_body_len[IDX_W:0];
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (mispredict) begin
          state_d = IDLE;
        end else if (curr_PC == tgt_q) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          idx_d     = IDX_W'(1);
          state_d   = CAPTURE;
        end else if (w_is_branch && (curr_PC != br_q)) begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (mispredict || w_capture_abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          buf_we = 1'b1;
          idx_d  = idx_q + IDX_W'(1);
          if ((curr_PC == br_q) && w_is_branch) begin
            state_d = STREAM;
            idx_d   = '0;
          end
        end
      end
      STREAM: begin
        if (mispredict) begin
          flush_d  = 1'b1;
          new_pc_d = br_q + 32'd4;
          state_d  = IDLE;
          idx_d    = '0;
        end else begin
          idx_d = w_last_rd ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      tgt_q    <= '0;
      br_q     <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      tgt_q    <= tgt_d;
      br_q     <= br_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  loop_buffer #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (instruction),
    .raddr_i (idx_q),
    .rdata_o (buf_rdata)
  );

  assign block_signal    = (state_q == STREAM);
  assign reuse_signal    = (state_q == STREAM);
  assign out_instruction = (state_q == STREAM) ? buf_rdata : instruction;
  assign flush           = flush_q;
  assign new_pc          = new_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_loop_detector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stream_loop_detector : directed + random bench with a queue-based|
// | reference model of the loop detector. rev 1.0                      |
// +--------------------------------------------------------------------+
module tb_stream_loop_detector;

  localparam int         DEPTH = 16;
  localparam logic [6:0] OPC   = 7'b1100011;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_STREAM = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] curr_PC = '0, instruction = '0, immediate = '0;
  logic        mispredict = 1'b0;
  logic [31:0] out_instruction, new_pc;
  logic        block_signal, flush, reuse_signal;

  stream_loop_detector #(.DEPTH(DEPTH), .IDX_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .curr_PC         (curr_PC),
    .instruction     (instruction),
    .immediate       (immediate),
    .mispredict      (mispredict),
    .out_instruction (out_instruction),
    .block_signal    (block_signal),
    .flush           (flush),
    .new_pc          (new_pc),
    .reuse_signal    (reuse_signal)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: body kept as a queue, replay position as modulo count.
  int          m_mode = M_IDLE;
  logic [31:0] m_branch = '0, m_target = '0, m_newpc = '0;
  int          m_len = 0, m_pos = 0;
  logic        m_flush = 1'b0;
  logic [31:0] m_body[$];

  task automatic model_step(input bit rst_n, input logic [31:0] pc, ins, imm, input bit mp);
    bit          is_br;
    longint      simm;
    logic [31:0] exp_pc;
    logic        nflush;
    logic [31:0] nnewpc;
    nflush = 1'b0;
    nnewpc = '0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_pos = 0; m_len = 0; m_branch = '0; m_target = '0;
      m_flush = 1'b0; m_newpc = '0; m_body.delete();
      return;
    end
    is_br = (ins[6:0] == OPC);
    simm  = longint'($signed(imm));
    case (m_mode)
      M_IDLE: if (!mp && is_br && imm[31] && (1 - simm) <= DEPTH) begin
        m_branch = pc;
        m_target = pc + (imm << 2);
        m_len    = int'(1 - simm);
        m_mode   = M_ARMED;
      end
      M_ARMED: begin
        if (mp) m_mode = M_IDLE;
        else if (pc == m_target) begin
          m_body.delete();
          m_body.push_back(ins);
          m_mode = M_CAPT;
        end else if (is_br && pc != m_branch) m_mode = M_IDLE;
      end
      M_CAPT: begin
        exp_pc = m_target + 32'(4 * m_body.size());
        if (mp || pc < m_target || pc > m_branch || pc != exp_pc || m_body.size() >= m_len)
          m_mode = M_IDLE;
        else begin
          m_body.push_back(ins);
          if (pc == m_branch && is_br) begin
            m_mode = M_STREAM;
            m_pos  = 0;
          end
        end
      end
      default: begin
        if (mp) begin
          nflush = 1'b1;
          nnewpc = m_branch + 32'd4;
          m_mode = M_IDLE;
        end else m_pos = (m_pos + 1) % m_len;
      end
    endcase
    m_flush = nflush;
    m_newpc = nnewpc;
  endtask

  logic [31:0] s_out, s_npc;
  logic        s_blk, s_reuse, s_flush;
  logic        seen_blk = 1'b0, seen_flush = 1'b0;

  task automatic run_cycle(input bit rst_n, input logic [31:0] pc, ins, imm, input bit mp);
    logic [31:0] exp_out;
    @(negedge clk);
    reset = rst_n; curr_PC = pc; instruction = ins; immediate = imm; mispredict = mp;
    #1;
    exp_out = (m_mode == M_STREAM) ? m_body[m_pos] : ins;
    chk("block", 32'(block_signal), 32'(m_mode == M_STREAM));
    chk("reuse", 32'(reuse_signal), 32'(m_mode == M_STREAM));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc", new_pc, m_newpc);
    chk("out", out_instruction, exp_out);
    s_out = out_instruction; s_npc = new_pc;
    s_blk = block_signal; s_reuse = reuse_signal; s_flush = flush;
    seen_blk   = seen_blk | block_signal;
    seen_flush = seen_flush | flush;
    @(posedge clk);
    model_step(rst_n, pc, ins, imm, mp);
  endtask

  task automatic cyc(input logic [31:0] pc, ins, imm, input bit mp);
    run_cycle(1'b1, pc, ins, imm, mp);
  endtask

  logic [31:0] dl [4] = '{32'h13, 32'h14, 32'h15, 32'hFC000AE3};

  // passes over the 0x100 loop; mispredict on pass mp_pass at index mp_idx
  task automatic dloop(input int passes, input int mp_pass, input int mp_idx);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 4; i++)
        cyc(32'h100 + 32'(4 * i), dl[i], (i == 3) ? 32'hFFFFFFFD : 32'h0,
            (p == mp_pass) && (i == mp_idx));
  endtask

  task automatic long_loop(input logic [31:0] bpc, input int len, input int passes);
    logic [31:0] imm;
    imm = 32'(1 - len);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++)
        cyc(bpc - 32'(4 * (len - 1 - i)), (i == len - 1) ? 32'hFE000CE3 : 32'h13,
            (i == len - 1) ? imm : 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_nonbr();
    logic [31:0] v;
    v = $urandom;
    if (v[6:0] == OPC) v[6:0] = 7'h13;
    return v;
  endfunction

  function automatic logic [31:0] rand_br();
    logic [31:0] v;
    v = $urandom;
    v[6:0] = OPC;
    return v;
  endfunction

  initial begin
    logic [31:0] ins, rb;
    logic [31:0] body [20];
    logic [31:0] base, imm, pc;
    int L, iters, n;

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step(1'b0, '0, '0, '0, 1'b0);

    // reset state
    run_cycle(1'b0, '0, '0, '0, 1'b0);
    run_cycle(1'b0, '0, '0, '0, 1'b0);
    chk("rst_block", 32'(s_blk), 32'd0);
    chk("rst_flush", 32'(s_flush), 32'd0);
    chk("rst_reuse", 32'(s_reuse), 32'd0);
    chk("rst_newpc", s_npc, 32'd0);

    // capture then replay
    dloop(2, -1, -1);
    for (int k = 0; k < 8; k++) begin
      cyc($urandom, $urandom, $urandom, 1'b0);
      chk("stream_out", s_out, dl[k % 4]);
      chk("stream_blk", 32'(s_blk), 32'd1);
    end
    cyc($urandom, $urandom, 32'h0, 1'b1);
    chk("exit_blk_before", 32'(s_blk), 32'd1);
    cyc(32'h110, 32'h13, 32'h0, 1'b0);
    chk("exit_flush", 32'(s_flush), 32'd1);
    chk("exit_newpc", s_npc, 32'h110);
    chk("exit_blk", 32'(s_blk), 32'd0);
    cyc(32'h114, 32'h00A00093, 32'h0, 1'b0);
    chk("post_flush", 32'(s_flush), 32'd0);
    chk("post_blk", 32'(s_blk), 32'd0);
    chk("post_bypass", s_out, 32'h00A00093);

    // re-entry, then mispredict during capture pass re-arms without flush
    dloop(2, -1, -1);
    cyc(32'h110, 32'h13, 32'h0, 1'b0);
    chk("reentry_stream", 32'(s_blk), 32'd1);
    chk("reentry_out", s_out, 32'h13);
    cyc(32'h110, 32'h13, 32'h0, 1'b1);
    cyc(32'h110, 32'h13, 32'h0, 1'b0);
    seen_flush = 1'b0;
    dloop(3, 1, 1);
    chk("reentry_noflush", 32'(seen_flush), 32'd0);
    cyc(32'h110, 32'h13, 32'h0, 1'b0);
    chk("rearm_stream", 32'(s_blk), 32'd1);
    run_cycle(1'b0, '0, '0, '0, 1'b0);

    // too long (21 instructions) never streams; exactly DEPTH does
    seen_blk = 1'b0;
    long_loop(32'h300, 21, 3);
    chk("toolong_blk", 32'(seen_blk), 32'd0);
    long_loop(32'h400, DEPTH, 2);
    cyc(32'h404, 32'h13, 32'h0, 1'b0);
    chk("depth_stream", 32'(s_blk), 32'd1);
    run_cycle(1'b0, '0, '0, '0, 1'b0);

    // broken capture
    seen_blk = 1'b0;
    dloop(1, -1, -1);
    cyc(32'h100, dl[0], 32'h0, 1'b0);
    cyc(32'h104, dl[1], 32'h0, 1'b0);
    cyc(32'h200, 32'h13, 32'h0, 1'b0);
    cyc(32'h108, dl[2], 32'h0, 1'b0);
    cyc(32'h10C, dl[3], 32'hFFFFFFFD, 1'b0);
    cyc(32'h110, 32'h13, 32'h0, 1'b0);
    chk("broken_blk", 32'(seen_blk), 32'd0);
    run_cycle(1'b0, '0, '0, '0, 1'b0);

    // randomized loops
    for (int r = 0; r < 80; r++) begin
      L     = $urandom_range(2, 19);
      imm   = 32'(1 - L);
      base  = 32'($urandom_range(0, 32'hFFFF)) << 2;
      iters = $urandom_range(1, 4);
      for (int i = 0; i < L - 1; i++) begin
        rb = rand_br();
        body[i] = ($urandom % 30 == 0) ? rb : rand_nonbr();
      end
      body[L-1] = rand_br();
      for (int it = 0; it < iters; it++)
        for (int i = 0; i < L; i++) begin
          pc  = ($urandom % 60 == 0) ? base + 32'(4 * (i + 1)) : base + 32'(4 * i);
          ins = body[i];
          run_cycle(($urandom % 300) != 0, pc, ins,
                    (i == L - 1) ? imm : 32'(-$urandom_range(1, 30)),
                    ($urandom % 50) == 0);
        end
      n = $urandom_range(0, 3 * L);
      for (int k = 0; k < n; k++) cyc($urandom, $urandom, $urandom, 1'b0);
      cyc($urandom, rand_nonbr(), $urandom, 1'b1);
      cyc($urandom, rand_nonbr(), $urandom, 1'b0);
      cyc($urandom, rand_nonbr(), $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_loop_detector.md
Name: stream_loop_detector

Overview:
- Loop stream detector sitting beside the IF/ID register.
- Watches the decoded stream (curr_PC, instruction) for a short backward conditional branch and captures one full loop body into a small buffer.
- Then replays the body on out_instruction while asserting block_signal to stall fetch.
- A mispredict while replaying means the loop has exited: the block flushes and redirects fetch to the fall-through PC.

Parameters:
- DEPTH, 16, maximum loop body length in instructions, branch included.
- IDX_W, 4, buffer index width; equals clog2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- curr_PC  input  32  byte PC of the instruction currently in IF/ID.
- instruction  input  32  instruction currently in IF/ID.
- immediate  input  32  signed branch offset in instruction words; byte offset = immediate<<2.
- mispredict  input  1  branch-unit mispredict pulse.
- out_instruction  output  32  instruction delivered to decode.
- block_signal  output  1  stall fetch / IF-ID write; high while streaming.
- flush  output  1  one-cycle pipeline flush on loop exit.
- new_pc  output  32  fetch redirect target; valid only while flush=1.
- reuse_signal  output  1  high while out_instruction is sourced from the buffer.

Behaviour:
- All state updates on the rising clk edge.
- Reset: when reset=0 at an edge, go to IDLE and clear index, length, target_pc and branch_pc. block_signal, flush, reuse_signal and new_pc read 0.
- Branch qualifier: instruction[6:0]==7'b1100011, immediate negative (bit 31 = 1), and (-immediate+1) <= DEPTH.
- Loop addresses: target_pc = curr_PC + (immediate<<2); body length = -immediate+1.
- IDLE: a qualifying branch latches branch_pc=curr_PC, target_pc and length, then goes to ARMED.
- ARMED: when curr_PC==target_pc, write instruction to buf[0], set wr_idx=1, go to CAPTURE.
- ARMED abort: a branch at a PC other than branch_pc returns to IDLE.
- CAPTURE, each cycle: write instruction to buf[wr_idx] and increment wr_idx.
- CAPTURE completion: when curr_PC==branch_pc and the entry just written is the branch, go to STREAM with rd_idx=0.
- CAPTURE abort, return to IDLE: curr_PC outside [target_pc, branch_pc], curr_PC not equal to target_pc + 4*wr_idx, or wr_idx would exceed length.
- STREAM outputs: block_signal=1, reuse_signal=1, out_instruction=buf[rd_idx].
- STREAM indexing: rd_idx increments each cycle and wraps from length-1 to 0. curr_PC and instruction are ignored.
- Non-STREAM output: out_instruction = instruction (combinational bypass).
- Mispredict in STREAM, next cycle:
  - flush=1 for exactly one cycle;
  - new_pc = branch_pc + 4;
  - block_signal=0, reuse_signal=0;
  - state returns to IDLE and rd_idx clears.
- Mispredict in ARMED or CAPTURE: return to IDLE with no flush.
- Mispredict in IDLE: ignored.
- Simultaneous events: mispredict has priority over branch detection and capture in the same cycle. reset has priority over everything.
- Reset mid-stream: outputs drop the following cycle; no flush is issued.
- After a flush the detector may re-detect the same loop; a full ARMED and CAPTURE pass is required again.
- new_pc and flush are registered. out_instruction in STREAM is a registered-index buffer read.

Decomposition:
- Package loop_det_pkg holds:
  - state enum IDLE/ARMED/CAPTURE/STREAM;
  - OPC_BRANCH=7'b1100011;
  - DEPTH default.
- One natural sub-module, loop_buffer: DEPTH x 32 register file with one write port and one read port.

Test Plan:
- Reset: hold reset=0 for 2 cycles → block_signal=0, flush=0, reuse_signal=0, new_pc=0.
- Loop capture:
  - stimulus: repeat PCs 0x100/0x104/0x108/0x10C with 0x13/0x14/0x15/0xFC000AE3; immediate=-3 at 0x10C;
  - first pass: ARMED;
  - second pass: captured;
  - from the cycle after the second 0x10C: block_signal=1, reuse_signal=1, out_instruction cycles 0x13,0x14,0x15,0xFC000AE3 with period 4.
- Exit: pulse mispredict one cycle during STREAM → next cycle flush=1 and new_pc=0x110; following cycle flush=0, block_signal=0, out_instruction=instruction.
- Re-entry:
  - stimulus: after exit, run two more iterations of the same loop;
  - response: streaming resumes;
  - a mispredict pulse during the fourth loop iteration, before streaming, gives no flush and re-arms.
- Too long: backward branch with immediate=-20 (DEPTH=16) → stays IDLE, block_signal never asserts.
- Broken capture: in CAPTURE, curr_PC jumps to 0x200 → return to IDLE, no streaming.
